// File: rtl/pipe_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the inter-stage pipeline registers:
//               per-boundary payload widths, control-bit indices and the
//               occupancy encoding of a skid-buffered stage.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Default payload widths, one pair per stage boundary.
    localparam int DEF_DATA_W   = 56;
    localparam int DEF_CTRL_W   = 6;
    localparam int IFID_DATA_W  = 32;
    localparam int IFID_CTRL_W  = 6;
    localparam int IDEX_DATA_W  = 56;
    localparam int IDEX_CTRL_W  = 6;
    localparam int EXMEM_DATA_W = 56;
    localparam int EXMEM_CTRL_W = 6;
    localparam int MEMWB_DATA_W = 40;
    localparam int MEMWB_CTRL_W = 6;

    // Bit positions of the control payload.
    localparam int MEMREAD  = 0;
    localparam int MEMWRITE = 1;
    localparam int REGWRITE = 2;
    localparam int MEMTOREG = 3;
    localparam int PCS      = 4;
    localparam int HALT     = 5;

    // Number of words held by a skid-buffered stage.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    // Occupancy from the two slot valid bits (skid valid implies main valid).
    function automatic logic [1:0] occ_of(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage
`default_nettype wire

// File: rtl/dff.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : dff
// Description : Generic W-bit register with load enable and asynchronous
//               active-low reset to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module dff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    // Capture on enable; reset clears immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_slot.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_slot
// Description : One entry of a pipeline stage: valid bit plus control and
//               data payload. Load sets valid and captures the payload; clear
//               drops valid and wins over load. Payload is left untouched by
//               clear.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic              i_clr,
    input  logic [CTRL_W-1:0] i_ctrl,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [CTRL_W-1:0] o_ctrl,
    output logic [DATA_W-1:0] o_data
);

    logic                     w_valid_d;
    logic [CTRL_W+DATA_W-1:0] w_payload_q;

    // Next valid: clear has priority, then load, otherwise hold.
    always_comb begin
        w_valid_d = o_valid;
        if (i_clr) begin
            w_valid_d = 1'b0;
        end else if (i_load) begin
            w_valid_d = 1'b1;
        end
    end

    dff #(.W(1)) u_valid (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (1'b1),
        .i_d   (w_valid_d),
        .o_q   (o_valid)
    );

    dff #(.W(CTRL_W + DATA_W)) u_payload (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en  (i_load),
        .i_d   ({i_ctrl, i_data}),
        .o_q   (w_payload_q)
    );

    assign o_ctrl = w_payload_q[CTRL_W+DATA_W-1:DATA_W];
    assign o_data = w_payload_q[DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/pipe_stage_skid.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pipe_stage_skid
// Description : Valid/ready pipeline-stage register with a two-entry skid
//               buffer (MAIN + SKID), synchronous flush, bubble gating of the
//               control payload and a saturating back-pressure counter.
//               in_ready is a pure function of registered state.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int CTRL_W = DEF_CTRL_W,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic              w_main_v;
    logic [CTRL_W-1:0] w_main_ctrl;
    logic [DATA_W-1:0] w_main_data;
    logic              w_skid_v;
    logic [CTRL_W-1:0] w_skid_ctrl;
    logic [DATA_W-1:0] w_skid_data;

    logic              w_accept;
    logic              w_release;
    logic              w_main_load;
    logic              w_main_clr;
    logic              w_skid_load;
    logic              w_skid_clr;
    logic [CTRL_W-1:0] w_main_ctrl_d;
    logic [DATA_W-1:0] w_main_data_d;

    logic [CNT_W-1:0]  r_stall_cnt;

    assign in_ready  = ~w_skid_v;
    assign w_accept  = in_valid & in_ready;
    assign w_release = w_main_v & out_ready;

    // Slot load/clear decisions and MAIN source selection (SKID first, FIFO order).
    always_comb begin
        w_main_load   = 1'b0;
        w_main_clr    = 1'b0;
        w_skid_load   = 1'b0;
        w_skid_clr    = 1'b0;
        w_main_ctrl_d = in_ctrl;
        w_main_data_d = in_data;

        if (!w_main_v) begin
            w_main_load = w_accept;
        end else if (w_release) begin
            if (w_skid_v) begin
                w_main_load   = 1'b1;
                w_main_ctrl_d = w_skid_ctrl;
                w_main_data_d = w_skid_data;
                w_skid_clr    = 1'b1;
            end else if (w_accept) begin
                w_main_load = 1'b1;
            end else begin
                w_main_clr = 1'b1;
            end
        end else begin
            w_skid_load = w_accept;
        end

        // Squash both entries; a release this cycle has already completed.
        if (flush) begin
            w_main_clr = 1'b1;
            w_skid_clr = 1'b1;
        end
    end

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_main (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_main_load),
        .i_clr   (w_main_clr),
        .i_ctrl  (w_main_ctrl_d),
        .i_data  (w_main_data_d),
        .o_valid (w_main_v),
        .o_ctrl  (w_main_ctrl),
        .o_data  (w_main_data)
    );

    pipe_slot #(
        .CTRL_W (CTRL_W),
        .DATA_W (DATA_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_skid_load),
        .i_clr   (w_skid_clr),
        .i_ctrl  (in_ctrl),
        .i_data  (in_data),
        .o_valid (w_skid_v),
        .o_ctrl  (w_skid_ctrl),
        .o_data  (w_skid_data)
    );

    // Count cycles where a word is offered but not taken, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_main_v && !out_ready && (r_stall_cnt != c_cnt_max)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    // An empty stage must never present live control bits downstream.
    assign out_valid = w_main_v;
    assign out_ctrl  = w_main_ctrl & {CTRL_W{w_main_v}};
    assign out_data  = w_main_data;
    assign occupancy = occ_of(w_main_v, w_skid_v);
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_skid.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_skid
// Description : Self-checking bench for pipe_stage_skid. A queue-based model
//               of a two-deep FIFO stage predicts every output each cycle;
//               directed phases cover reset, streaming, back-pressure, flush,
//               bubble gating and counter saturation, then random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_skid;
    import pipe_pkg::*;

    localparam int DW = 56;
    localparam int CW = 6;
    localparam int NW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [CW-1:0] in_ctrl = '0;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [CW-1:0] out_ctrl;
    logic [DW-1:0] out_data;
    logic [1:0]    occupancy;
    logic [NW-1:0] stall_cnt;

    pipe_stage_skid #(
        .DATA_W (DW),
        .CTRL_W (CW),
        .CNT_W  (NW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ctrl  (out_ctrl),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } word_t;

    // Reference model: a stage is a FIFO of capacity two.
    word_t         m_q[$];
    int unsigned   m_cnt;
    logic [DW-1:0] m_last;
    bit            m_known;
    bit            m_acc;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_cnt   = 0;
        m_last  = '0;
        m_known = 1'b1;
        m_acc   = 1'b0;
    endtask

    task automatic compare();
        logic [CW-1:0] e_ctrl;
        logic [DW-1:0] e_data;
        e_ctrl = '0;
        e_data = m_last;
        if (m_q.size() > 0) begin
            e_ctrl = m_q[0].c;
            e_data = m_q[0].d;
        end
        chk("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        chk("in_ready",  64'(in_ready),  64'(m_q.size() < 2));
        chk("occupancy", 64'(occupancy), 64'(m_q.size()));
        chk("out_ctrl",  64'(out_ctrl),  64'(e_ctrl));
        if (m_q.size() > 0 || m_known)
            chk("out_data", 64'(out_data), 64'(e_data));
        chk("stall_cnt", 64'(stall_cnt), 64'(m_cnt));
    endtask

    // One clock: advance the model with the inputs seen at the edge, then
    // compare on the falling edge.
    task automatic step();
        bit acc;
        bit rel;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            acc = in_valid && (m_q.size() < 2);
            rel = (m_q.size() > 0) && out_ready;
            if ((m_q.size() > 0) && !out_ready && (m_cnt < (2**NW - 1)))
                m_cnt++;
            if (flush) begin
                m_q.delete();
                m_known = 1'b0;
            end else begin
                if (rel) void'(m_q.pop_front());
                if (acc) m_q.push_back(word_t'{in_ctrl, in_data});
            end
            if (m_q.size() > 0) begin
                m_last  = m_q[0].d;
                m_known = 1'b1;
            end
            m_acc = acc && !flush;
        end
        @(negedge clk);
        compare();
    endtask

    initial begin
        model_reset();

        // Reset with an active-looking input.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_ctrl  = 6'h3F;
        in_data  = 56'hAB_CDEF;
        repeat (3) step();

        // First word after reset.
        rst_n    = 1'b1;
        in_data  = 56'h1234;
        step();
        chk("first_word", 64'(out_data), 64'h1234);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();

        // Streaming 0..7 at full rate.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_ctrl  = CW'(i);
            in_data  = DW'(i);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();

        // Back-pressure with A, B, C.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 6'h01; in_data = 56'hA;
        step();
        in_ctrl   = 6'h02; in_data = 56'hB;
        step();
        in_ctrl   = 6'h04; in_data = 56'hC;
        repeat (2) step();
        chk("bp_in_ready", 64'(in_ready), 64'd0);
        chk("bp_occupancy", 64'(occupancy), 64'd2);
        out_ready = 1'b1;
        begin
            int budget = 8;
            do begin
                step();
                budget--;
            end while (!m_acc && budget > 0);
            if (!m_acc) chk("bp_c_accept_timeout", 64'd0, 64'd1);
        end
        in_valid = 1'b0;
        repeat (3) step();

        // Flush with a full stage and a concurrent input.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_ctrl   = 6'h3F; in_data = 56'h11;
        step();
        in_data   = 56'h22;
        step();
        flush     = 1'b1;
        in_data   = 56'hDEAD;
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        chk("flush_occupancy", 64'(occupancy), 64'd0);
        out_ready = 1'b1;
        repeat (2) step();

        // Bubble gating of MemWrite.
        in_valid = 1'b1;
        in_ctrl  = CW'(1) << MEMWRITE;
        in_data  = 56'h5A5A;
        step();
        in_valid = 1'b0;
        step();
        chk("bubble_memwrite", 64'(out_ctrl[MEMWRITE]), 64'd0);

        // Stall counter saturation.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 56'h77;
        step();
        in_valid  = 1'b0;
        repeat (20) step();
        chk("stall_sat", 64'(stall_cnt), 64'd15);

        // Asynchronous reset between edges.
        #2 rst_n = 1'b0;
        #1;
        chk("async_stall_cnt", 64'(stall_cnt), 64'd0);
        chk("async_out_valid", 64'(out_valid), 64'd0);
        model_reset();
        step();
        rst_n = 1'b1;
        step();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_ctrl   = CW'($urandom);
            in_data   = {24'($urandom), 32'($urandom)};
            out_ready = ($urandom_range(0, 9) < 6);
            flush     = ($urandom_range(0, 31) == 0);
            step();
        end
        flush    = 1'b0;
        in_valid = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
